// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-write-port register file: two read ports, two write
// ports, the issue port and the scoreboard outputs.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // No handshake: every input is sampled on every rising clk edge, and every
    // output except busy_cnt is a combinational function of inputs and state.
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr0_en;
    logic [AW-1:0]   wr0_rd;
    logic [XLEN-1:0] wr0_data;
    logic            wr1_en;
    logic [AW-1:0]   wr1_rd;
    logic [XLEN-1:0] wr1_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic [AW:0]     busy_cnt;

    modport master (
        output rs1, rs2, wr0_en, wr0_rd, wr0_data, wr1_en, wr1_rd, wr1_data,
               issue_en, issue_rd,
        input  readData1, readData2, rs1_busy, rs2_busy, busy_cnt
    );

    modport slave (
        input  rs1, rs2, wr0_en, wr0_rd, wr0_data, wr1_en, wr1_rd, wr1_data,
               issue_en, issue_rd,
        output readData1, readData2, rs1_busy, rs2_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-write/two-read integer register file with same-cycle write-to-read bypass
// and an integrated busy-bit scoreboard for hazard detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_cnt_q;

    logic            w0_en;
    logic [AW-1:0]   w0_rd;
    logic [XLEN-1:0] w0_data;
    logic            w1_en;
    logic [AW-1:0]   w1_rd;
    logic [XLEN-1:0] w1_data;

    assign w0_en   = bus.wr0_en;
    assign w0_rd   = bus.wr0_rd;
    assign w0_data = bus.wr0_data;
    assign w1_en   = bus.wr1_en;
    assign w1_rd   = bus.wr1_rd;
    assign w1_data = bus.wr1_data;

    function automatic logic is_prot(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic wr_hit(input logic [AW-1:0] a);
        return (w0_en && (w0_rd == a)) || (w1_en && (w1_rd == a));
    endfunction

    // Port 1 is checked first so it wins a same-address collision on the bypass.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (is_prot(a))
            return '0;
        else if (w1_en && (w1_rd == a))
            return w1_data;
        else if (w0_en && (w0_rd == a))
            return w0_data;
        else
            return regs[a];
    endfunction

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++)
            c = c + {{AW{1'b0}}, v[i]};
        return c;
    endfunction

    assign bus.readData1 = read_port(bus.rs1);
    assign bus.readData2 = read_port(bus.rs2);

    // A retiring write hides the busy bit in the same cycle, matching the data bypass.
    assign bus.rs1_busy  = busy[bus.rs1] && !wr_hit(bus.rs1);
    assign bus.rs2_busy  = busy[bus.rs2] && !wr_hit(bus.rs2);
    assign bus.busy_cnt  = busy_cnt_q;

    // A new issue supersedes a same-cycle retirement of the previous producer.
    always_comb begin
        busy_next = busy;
        for (int r = 0; r < NREG; r++) begin
            if (bus.issue_en && (bus.issue_rd == AW'(r)) && !is_prot(AW'(r)))
                busy_next[r] = 1'b1;
            else if (wr_hit(AW'(r)))
                busy_next[r] = 1'b0;
            else
                busy_next[r] = busy[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (w0_en && !is_prot(w0_rd))
                regs[w0_rd] <= w0_data;
            if (w1_en && !is_prot(w1_rd))
                regs[w1_rd] <= w1_data;
            busy       <= busy_next;
            busy_cnt_q <= popcount(busy_next);
        end
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-write-port integer register file for the pipelined core; successor to the single-write-port 32x32 file.
- Two write ports (ALU/early writeback on port 0, load/late writeback on port 1) and two read ports, both with same-cycle write-to-read bypass.
- Integrated busy-bit scoreboard: decode marks a destination pending at issue; writeback clears it. Hazard logic can stall on rs busy without a separate tracker.

Parameters:
- XLEN, 32, data width of each register in bits.
- AW, 5, register address width; NREG = 2**AW registers.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy; when 0 register 0 is an ordinary register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- rs1  in  AW  read address A
- rs2  in  AW  read address B
- readData1  out  XLEN  read data A (combinational)
- readData2  out  XLEN  read data B (combinational)
- rs1_busy  out  1  register rs1 has a pending producer (combinational)
- rs2_busy  out  1  register rs2 has a pending producer (combinational)
- wr0_en  in  1  write port 0 enable
- wr0_rd  in  AW  write port 0 address
- wr0_data  in  XLEN  write port 0 data
- wr1_en  in  1  write port 1 enable (higher priority)
- wr1_rd  in  AW  write port 1 address
- wr1_data  in  XLEN  write port 1 data
- issue_en  in  1  mark issue_rd pending this cycle
- issue_rd  in  AW  destination being issued
- busy_cnt  out  AW+1  number of registers currently busy (registered)

Behaviour:
- Reset: on a clk edge with rst=1, every register is set to 0, all busy bits are set to 0 and busy_cnt is set to 0. Writes and issue in that cycle are ignored. After reset, every read returns 0 and no register is busy.
- Protected register: "protected" means ZERO_REG=1 and address 0. A protected register reads 0, ignores writes, ignores issue_en and is never busy.
- Write: on the clk edge, wrN_en=1 stores wrN_data at wrN_rd.
- Write collision: if both ports write the same address in the same cycle, port 1's data is stored.
- Read path, combinational, evaluated in this priority order:
  1. Protected address returns 0.
  2. If wr1_en and wr1_rd equals the read address, return wr1_data.
  3. Else if wr0_en and wr0_rd equals the read address, return wr0_data.
  4. Otherwise return the array contents.
- Bypass applies to both read ports independently.
- Scoreboard, next state of busy[r]:
  - Set if issue_en and issue_rd=r, and r is not protected.
  - Else clear if (wr0_en and wr0_rd=r) or (wr1_en and wr1_rd=r).
  - Else hold.
  - Set wins over clear when both occur in the same cycle (a new producer supersedes the retiring one).
  - Issue to an already-busy register keeps it busy.
  - A write to a non-busy register is legal and leaves it clear.
- rsX_busy = busy[rsX] and not (a write to rsX this cycle). The same-cycle clear is bypassed so that it pairs with the data bypass. A same-cycle issue does not set rsX_busy until the next cycle.
- busy_cnt: registered population count of the busy bits, updated on the same edge as the busy bits. Range is 0..NREG, or NREG-1 when ZERO_REG=1. It never wraps.
- Latency: write-to-array 1 cycle; write-to-read 0 cycles via bypass; issue-to-busy 1 cycle.
- No internal handshake or stall: all inputs are sampled every cycle.

Test Plan:
- Reset then read: assert rst one cycle with wr0_en=1, rd=3, data=0xDEAD -> afterwards readData1 for rs1=3 is 0x00000000, busy_cnt=0, rs1_busy=0.
- Dual-write collision: wr0 rd=5 data=0x11111111 and wr1 rd=5 data=0x22222222 in the same cycle -> the same-cycle read of rs1=5 returns 0x22222222; the next-cycle read returns 0x22222222. Separately, wr0 rd=6 data=0xA and wr1 rd=7 data=0xB -> x6=0xA, x7=0xB.
- Register zero: write x0=0xFFFFFFFF and issue_rd=0 -> readData2 for rs2=0 is 0, rs2_busy=0, busy_cnt unchanged.
- Scoreboard life cycle: issue rd=8 -> next cycle rs1=8 gives rs1_busy=1 and busy_cnt=1. Then in the cycle wr1 writes x8=0x55 -> rs1_busy=0 and readData1=0x55 that same cycle; busy_cnt=0 after the edge.
- Set-over-clear: issue rd=9 while wr0 writes x9 in the same cycle (x9 previously busy) -> x9 remains busy next cycle and busy_cnt is unchanged.
- Full occupancy: issue x1..x31 over 31 cycles -> busy_cnt=31. Assert rst -> busy_cnt=0 on the next edge.
